// File: rtl/inst_fifo_if.sv
// rtl/inst_fifo_if.sv - pre-decoder/decode handshake bundle for the instruction FIFO
interface inst_fifo_if;
  logic              flush;
  logic [2:0][31:0]  inst_in;
  logic [2:0][31:0]  pc_in;
  logic [2:0]        pred_in;
  logic [2:0]        valid_in;
  logic              ready_ifr;
  logic [2:0][31:0]  inst_out;
  logic [2:0][31:0]  pc_out;
  logic [2:0]        pred_out;
  logic [2:0]        valid_out;
  logic              ready_dec;

  modport master (
    output flush, inst_in, pc_in, pred_in, valid_in, ready_dec,
    input  ready_ifr, inst_out, pc_out, pred_out, valid_out
  );

  modport slave (
    input  flush, inst_in, pc_in, pred_in, valid_in, ready_dec,
    output ready_ifr, inst_out, pc_out, pred_out, valid_out
  );
endinterface

// File: rtl/inst_fifo.sv
// rtl/inst_fifo.sv - 3-wide in / 3-wide out instruction FIFO; INST_FIFO_STAT_EN adds stall_cnt
module inst_fifo #(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef INST_FIFO_STAT_EN
  output logic [31:0]  stall_cnt,
`endif
  inst_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]      inst_mem [DEPTH];
  logic [31:0]      pc_mem   [DEPTH];
  logic [DEPTH-1:0] pred_mem;

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ready;
  logic          push_en;
  logic [1:0]    n_push, n_pop;
  logic [AW-1:0] rd_idx;

  // Three free slots are always reserved so a full group never needs splitting.
  assign ready   = (count_q <= (AW+1)'(DEPTH - 3));
  assign push_en = ready && (|bus.valid_in) && !bus.flush;
  assign bus.ready_ifr = ready;

  always_comb begin
    n_push = 2'd0;
    n_pop  = 2'd0;
    if (push_en)
      n_push = 2'(bus.valid_in[0]) + 2'(bus.valid_in[1]) + 2'(bus.valid_in[2]);
    if (bus.ready_dec && !bus.flush)
      n_pop = (count_q >= (AW+1)'(3)) ? 2'd3 : count_q[1:0];
    wptr_d  = wptr_q + {{(AW-2){1'b0}}, n_push};
    rptr_d  = rptr_q + {{(AW-2){1'b0}}, n_pop};
    count_d = count_q + {{(AW-1){1'b0}}, n_push} - {{(AW-1){1'b0}}, n_pop};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push_en && bus.valid_in[i]) begin
        inst_mem[wptr_q + AW'(i)] <= bus.inst_in[i];
        pc_mem[wptr_q + AW'(i)]   <= bus.pc_in[i];
        pred_mem[wptr_q + AW'(i)] <= bus.pred_in[i];
      end
    end
  end

  always_comb begin
    rd_idx = '0;
    for (int i = 0; i < 3; i++) begin
      rd_idx = rptr_q + AW'(i);
      bus.inst_out[i]  = inst_mem[rd_idx];
      bus.pc_out[i]    = pc_mem[rd_idx];
      bus.pred_out[i]  = pred_mem[rd_idx];
      bus.valid_out[i] = (count_q > (AW+1)'(i));
    end
  end

`ifdef INST_FIFO_STAT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt_q <= '0;
    else if ((|bus.valid_in) && !ready && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_inst_fifo.sv
// tb/tb_inst_fifo.sv - directed self-checking bench for inst_fifo (DEPTH=16)
module tb_inst_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
`ifdef INST_FIFO_STAT_EN
  logic [31:0] stall_cnt;
`endif

  inst_fifo_if ff();

  inst_fifo #(.DEPTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef INST_FIFO_STAT_EN
    .stall_cnt (stall_cnt),
`endif
    .bus       (ff.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      checks++;
      assert (ff.valid_in inside {3'b000, 3'b001, 3'b011, 3'b111}) else begin
        failures++;
        $error("FAIL valid_in_legal observed=%b expected=prefix", ff.valid_in);
      end
    end
  end

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return pc ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] m, input logic [31:0] pc0, input logic [2:0] pr,
                       input logic rdy);
    ff.valid_in  = m;
    ff.pred_in   = pr;
    ff.ready_dec = rdy;
    for (int i = 0; i < 3; i++) begin
      ff.pc_in[i]   = pc0 + 32'(4 * i);
      ff.inst_in[i] = ins(pc0 + 32'(4 * i));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ff.flush = 1'b0;
    drive(3'b000, 32'h0, 3'b000, 1'b0);
    #2;
    chk("reset_valid_out", 32'(ff.valid_out), 32'b000);
    chk("reset_ready_ifr", 32'(ff.ready_ifr), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_valid_out", 32'(ff.valid_out), 32'b000);

    // first group, pred on middle slot
    drive(3'b111, 32'h1C00_0000, 3'b010, 1'b0);
    tick();
    drive(3'b000, 32'h0, 3'b000, 1'b0);
    chk("g1_valid_out", 32'(ff.valid_out), 32'b111);
    chk("g1_pc0", ff.pc_out[0], 32'h1C00_0000);
    chk("g1_pc1", ff.pc_out[1], 32'h1C00_0004);
    chk("g1_pc2", ff.pc_out[2], 32'h1C00_0008);
    chk("g1_inst0", ff.inst_out[0], 32'hC2AD_0000);
    chk("g1_pred", 32'(ff.pred_out), 32'b010);
    drive(3'b000, 32'h0, 3'b000, 1'b1);
    tick();
    chk("g1_pop_valid_out", 32'(ff.valid_out), 32'b000);

    // 001 then 011, order preserved
    drive(3'b001, 32'h100, 3'b000, 1'b0);
    tick();
    chk("p001_valid_out", 32'(ff.valid_out), 32'b001);
    drive(3'b011, 32'h104, 3'b000, 1'b0);
    tick();
    chk("p011_valid_out", 32'(ff.valid_out), 32'b111);
    chk("p011_pc0", ff.pc_out[0], 32'h100);
    chk("p011_pc1", ff.pc_out[1], 32'h104);
    chk("p011_pc2", ff.pc_out[2], 32'h108);
    drive(3'b000, 32'h0, 3'b000, 1'b1);
    tick();
    chk("p011_pop_valid_out", 32'(ff.valid_out), 32'b000);

    // fill to 15 with five groups
    for (int k = 0; k < 5; k++) begin
      drive(3'b111, 32'h200 + 32'(12 * k), 3'b000, 1'b0);
      tick();
      if (k == 3) chk("fill12_ready_ifr", 32'(ff.ready_ifr), 32'd1);
    end
    chk("fill15_ready_ifr", 32'(ff.ready_ifr), 32'd0);
    drive(3'b111, 32'h900, 3'b000, 1'b0);
    tick();
    drive(3'b000, 32'h0, 3'b000, 1'b0);
    chk("drop_ready_ifr", 32'(ff.ready_ifr), 32'd0);
    chk("drop_pc0", ff.pc_out[0], 32'h200);
`ifdef INST_FIFO_STAT_EN
    chk("drop_stall_cnt", stall_cnt, 32'd1);
`endif
    drive(3'b000, 32'h0, 3'b000, 1'b1);
    tick();
    chk("pop12_ready_ifr", 32'(ff.ready_ifr), 32'd1);
    chk("pop12_pc0", ff.pc_out[0], 32'h20C);

    // count 14: two free but not ready
    drive(3'b011, 32'h300, 3'b000, 1'b0);
    tick();
    chk("cnt14_ready_ifr", 32'(ff.ready_ifr), 32'd0);
    drive(3'b000, 32'h0, 3'b000, 1'b1);
    tick();
    tick();
    tick();
    drive(3'b000, 32'h0, 3'b000, 1'b0);
    chk("cnt5_pc0", ff.pc_out[0], 32'h230);
    chk("cnt5_ready_ifr", 32'(ff.ready_ifr), 32'd1);

    // simultaneous push 2 / pop 3 at count 5 -> 4
    drive(3'b011, 32'h400, 3'b000, 1'b1);
    tick();
    drive(3'b000, 32'h0, 3'b000, 1'b1);
    chk("pp_valid_out", 32'(ff.valid_out), 32'b111);
    chk("pp_pc0", ff.pc_out[0], 32'h300);
    chk("pp_pc2", ff.pc_out[2], 32'h400);
    tick();
    chk("pp_rem1_valid_out", 32'(ff.valid_out), 32'b001);
    chk("pp_rem1_pc0", ff.pc_out[0], 32'h404);
    tick();
    chk("empty_valid_out", 32'(ff.valid_out), 32'b000);
    tick();
    chk("empty_pop_valid_out", 32'(ff.valid_out), 32'b000);
    chk("empty_pop_ready_ifr", 32'(ff.ready_ifr), 32'd1);

    // wrap: pointers at 9 -> bring wptr to 14, then straddle 14,15,0
    drive(3'b111, 32'h500, 3'b000, 1'b0);
    tick();
    drive(3'b011, 32'h50C, 3'b000, 1'b1);
    tick();
    drive(3'b111, 32'h600, 3'b101, 1'b1);
    tick();
    drive(3'b000, 32'h0, 3'b000, 1'b0);
    chk("wrap_valid_out", 32'(ff.valid_out), 32'b111);
    chk("wrap_pc0", ff.pc_out[0], 32'h600);
    chk("wrap_pc1", ff.pc_out[1], 32'h604);
    chk("wrap_pc2", ff.pc_out[2], 32'h608);
    chk("wrap_inst2", ff.inst_out[2], 32'hDEAD_0608);
    chk("wrap_pred", 32'(ff.pred_out), 32'b101);

    // count 3 -> 7, then flush with push
    drive(3'b111, 32'h700, 3'b000, 1'b0);
    tick();
    drive(3'b001, 32'h70C, 3'b000, 1'b0);
    tick();
    chk("cnt7_ready_ifr", 32'(ff.ready_ifr), 32'd1);
    ff.flush = 1'b1;
    drive(3'b111, 32'h800, 3'b000, 1'b1);
    tick();
    ff.flush = 1'b0;
    drive(3'b000, 32'h0, 3'b000, 1'b0);
    chk("flush_valid_out", 32'(ff.valid_out), 32'b000);
    chk("flush_ready_ifr", 32'(ff.ready_ifr), 32'd1);
    drive(3'b111, 32'hA00, 3'b000, 1'b0);
    tick();
    drive(3'b000, 32'h0, 3'b000, 1'b0);
    chk("postflush_pc0", ff.pc_out[0], 32'hA00);
`ifdef INST_FIFO_STAT_EN
    chk("final_stall_cnt", stall_cnt, 32'd1);
`endif

    // asynchronous reset mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid_out", 32'(ff.valid_out), 32'b000);
    chk("async_rst_ready_ifr", 32'(ff.ready_ifr), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inst_fifo.md
# inst_fifo

Instruction buffer between the fetch-side pre-decoder and the decode stage. Each cycle it accepts up to three instructions in program order, given by a prefix valid mask from the pre-decoder together with each PC and a branch-predicted flag. Each cycle it presents up to three of the oldest buffered instructions to decode. It decouples fetch stalls from decode stalls and is emptied by a backend flush.

## Interface
- DEPTH, 16, number of entries; power of two, at least 8
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous flush from backend redirect
- inst_in[2:0]  in  32 each  instructions from pre-decoder, slot 0 oldest
- pc_in[2:0]  in  32 each  PCs of inst_in
- pred_in[2:0]  in  1 each  slot carries a taken prediction (redirect point)
- valid_in[2:0]  in  1 each  write mask; legal values 000, 001, 011, 111
- ready_ifr  out  1  FIFO can accept a full 3-slot group this cycle
- inst_out[2:0]  out  32 each  oldest instructions, slot 0 oldest
- pc_out[2:0]  out  32 each  PCs of inst_out
- pred_out[2:0]  out  1 each  stored prediction flags
- valid_out[2:0]  out  1 each  output slot holds a buffered entry; always a prefix mask
- ready_dec  in  1  decode consumes every valid output slot this cycle
- stall_cnt  out  32  only when INST_FIFO_STAT_EN is defined (see Configuration)

## Operation
- Storage is a circular array of DEPTH entries. Each entry holds {inst, pc, pred}.
- Pointers:
  - wptr and rptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is log2(DEPTH)+1 bits.
- Push:
  - A push occurs when ready_ifr is 1 and valid_in is not 000.
  - n_push = popcount(valid_in).
  - Slot i is written to entry (wptr+i) mod DEPTH.
  - wptr advances by n_push.
- ready_ifr = (count <= DEPTH-3), computed from the registered count only. It does not look ahead at a same-cycle pop.
- If valid_in is not 000 while ready_ifr is 0, the group is dropped and nothing is written. Upstream must hold the group.
- Output:
  - Slot i shows entry (rptr+i) mod DEPTH.
  - valid_out[i] = (count > i).
  - Output data for slots with valid_out low is don't-care.
- Pop:
  - A pop occurs when ready_dec is 1.
  - n_pop = popcount(valid_out), which is min(count, 3).
  - rptr advances by n_pop. Partial consumption is not supported.
- Count update: count_next = count + n_push - n_pop. Push and pop in the same cycle are both honoured.
- Flush:
  - Highest priority.
  - Next cycle: wptr = rptr = count = 0.
  - A push or pop in the flush cycle is discarded.
- Illegal valid_in masks (non-prefix) are undefined. The bench asserts they never occur.

## Timing
- Reset (asynchronous on rst_n low): wptr = rptr = count = 0, so valid_out = 000 and ready_ifr = 1. The storage array is not reset.
- Latency: an entry pushed at edge k is visible on inst_out after edge k. Minimum write-to-read latency is 1 cycle, with no combinational bypass.
- ready_ifr and valid_out depend only on registered state. There is no combinational path from any input to any output.
- Full boundary: at count = DEPTH-2, ready_ifr = 0 even though 2 entries are free. The 3-slot worst case is reserved.
- Empty boundary: at count = 0, ready_dec has no effect.
- Wrap-around: a group of three straddling index DEPTH-1 to 0 is written and read contiguously.
- Flush with rst_n high and push in the same cycle: FIFO is empty next cycle.
- Reset asserted mid-operation overrides everything immediately.

## Configuration
- INST_FIFO_STAT_EN defined:
  - Adds output stall_cnt[31:0].
  - stall_cnt increments every cycle in which valid_in is not 000 and ready_ifr is 0.
  - Saturates at 0xFFFF_FFFF.
  - Reset to 0 by rst_n only; flush does not clear it.
- INST_FIFO_STAT_EN undefined: the port and counter do not exist. All other behaviour is identical.

## Test plan
- Reset then idle -> valid_out = 000, ready_ifr = 1; push 111 with PCs 0x1C000000/4/8 -> next cycle valid_out = 111 with the same PCs in order.
- Push 001, then 011, with ready_dec = 0 -> count = 3, valid_out = 111, order preserved. Raise ready_dec -> next cycle valid_out = 000.
- Fill DEPTH = 16 with five 111 pushes -> count = 15, ready_ifr = 0. A push of 111 is dropped; with STAT_EN, stall_cnt = 1. Pop 3 -> ready_ifr = 1.
- Push and pop simultaneously at count = 5 (push 011, pop 3) -> count = 4.
- Wrap: advance pointers to wptr = 14, push 111 -> entries land at 14, 15, 0 and read back in order with pred flags intact.
- Flush asserted together with push 111 at count = 7 -> next cycle count = 0, valid_out = 000, ready_ifr = 1.
